// File: rtl/seq_divider_approx_tt_pkg.sv
// Shared types and truth-table constants for the approximate sequential divider.
package div_approx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Exact full-subtractor tables, bit index {x,y,bin}
  localparam logic [7:0] EXACT_DIFF_TT      = 8'h96;
  localparam logic [7:0] EXACT_BOUT_TT      = 8'h8E;

  // Reference approximate cell used by the exploration flow
  localparam logic [7:0] AD_113_125_DIFF_TT = 8'hBE;
  localparam logic [7:0] AD_113_125_BOUT_TT = 8'h8E;

endpackage

// File: rtl/seq_divider_approx_tt_if.sv
// Request/response bundle of the sequential divider.
interface seq_divider_approx_tt_if #(
  parameter int unsigned W = 8
) ();
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] n;
  logic [W-1:0]   d;
  logic           approx_en;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   q;
  logic [W-1:0]   r;
  logic           dbz;
  logic           ovf;
  logic           busy;

  modport master (
    output in_valid, n, d, approx_en, out_ready,
    input  in_ready, out_valid, q, r, dbz, ovf, busy
  );

  modport slave (
    input  in_valid, n, d, approx_en, out_ready,
    output in_ready, out_valid, q, r, dbz, ovf, busy
  );
endinterface

// File: rtl/seq_divider_approx_tt_sub_cell.sv
// One subtractor column: table-driven difference/borrow plus the restore mux.
module sub_cell_tt
  import div_approx_pkg::*;
#(
  parameter logic [7:0] DIFF_TT = AD_113_125_DIFF_TT,
  parameter logic [7:0] BOUT_TT = AD_113_125_BOUT_TT
) (
  input  logic x,
  input  logic y,
  input  logic bin,
  input  logic qs,
  input  logic sel_approx,
  output logic r_sub,
  output logic bout
);

  logic [2:0] idx;
  logic       diff;

  // Pick exact or approximate table, then keep x when the row does not subtract
  always_comb begin
    idx   = {x, y, bin};
    diff  = sel_approx ? DIFF_TT[idx] : EXACT_DIFF_TT[idx];
    bout  = sel_approx ? BOUT_TT[idx] : EXACT_BOUT_TT[idx];
    r_sub = qs ? diff : x;
  end

endmodule

// File: rtl/seq_divider_approx_tt.sv
// Radix-2 restoring divider, one quotient bit per cycle through a single W-cell row.
module seq_divider_approx_tt
  import div_approx_pkg::*;
#(
  parameter int unsigned W           = 8,
  parameter int unsigned APPROX_LSBS = 2,
  parameter logic [7:0]  DIFF_TT     = AD_113_125_DIFF_TT,
  parameter logic [7:0]  BOUT_TT     = AD_113_125_BOUT_TT
) (
  input logic                   clk,
  input logic                   rst,
  seq_divider_approx_tt_if.slave bus
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  state_t          state, state_nx;
  logic [W-1:0]    p_reg;
  logic [W-1:0]    low_reg;
  logic [W-1:0]    d_reg;
  logic [W-1:0]    q_acc;
  logic [W-1:0]    q_next;
  logic            mode;
  logic [CW-1:0]   cnt;

  logic            in_ready_r, out_valid_r, busy_r, dbz_r, ovf_r;
  logic [W-1:0]    q_r, r_r;

  logic [W-1:0]    x_row;
  logic [W-1:0]    rem_row;
  logic            guard;
  logic            qbit;
  logic            row_bout;

  // Row input: partial remainder shifted left with the next dividend bit; the bit shifted out is the guard
  assign guard = p_reg[W-1];
  assign x_row = {p_reg[W-2:0], low_reg[cnt]};

  // Ripple subtractor row; each column keeps its own borrow net
  for (genvar c = 0; c < W; c++) begin : g_cell
    localparam bit APPROX_COL = (c < APPROX_LSBS);
    logic bi;
    logic bo;
    logic rs;

    if (c == 0) begin : g_lsb
      assign bi = 1'b0;
    end else begin : g_chain
      assign bi = g_cell[c-1].bo;
    end

    sub_cell_tt #(
      .DIFF_TT (DIFF_TT),
      .BOUT_TT (BOUT_TT)
    ) u_cell (
      .x          (x_row[c]),
      .y          (d_reg[c]),
      .bin        (bi),
      .qs         (qbit),
      .sel_approx (mode & APPROX_COL),
      .r_sub      (rs),
      .bout       (bo)
    );

    assign rem_row[c] = rs;
  end

  assign row_bout = g_cell[W-1].bo;
  assign qbit     = guard | ~row_bout;

  // Quotient accumulator with the current bit merged in
  always_comb begin
    q_next      = q_acc;
    q_next[cnt] = qbit;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nx = BUSY;
      BUSY:    if (cnt == '0) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, status flags and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      p_reg       <= '0;
      low_reg     <= '0;
      d_reg       <= '0;
      q_acc       <= '0;
      mode        <= 1'b0;
      cnt         <= '0;
      q_r         <= '0;
      r_r         <= '0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      state       <= state_nx;
      in_ready_r  <= (state_nx == IDLE);
      out_valid_r <= (state_nx == DONE);
      busy_r      <= (state_nx == BUSY);
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            p_reg   <= bus.n[2*W-1:W];
            low_reg <= bus.n[W-1:0];
            d_reg   <= bus.d;
            mode    <= bus.approx_en;
            q_acc   <= '0;
            cnt     <= CW'(W - 1);
            dbz_r   <= (bus.d == '0);
            ovf_r   <= (bus.n[2*W-1:W] >= bus.d);
          end
        end
        BUSY: begin
          p_reg <= rem_row;
          q_acc <= q_next;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            q_r <= q_next;
            r_r <= rem_row;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.q         = q_r;
  assign bus.r         = r_r;
  assign bus.dbz       = dbz_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_seq_divider_approx_tt.sv
// Self-checking bench for seq_divider_approx_tt against a triangular-array reference model.
module tb_seq_divider_approx_tt;

  localparam int unsigned W           = 8;
  localparam int unsigned APPROX_LSBS = 2;
  localparam logic [7:0]  DIFF_TT     = 8'hBE;
  localparam logic [7:0]  BOUT_TT     = 8'h8E;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_divider_approx_tt_if #(.W(W)) bus ();

  seq_divider_approx_tt #(
    .W           (W),
    .APPROX_LSBS (APPROX_LSBS),
    .DIFF_TT     (DIFF_TT),
    .BOUT_TT     (BOUT_TT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] cap_q, cap_r;
  logic       cap_dbz, cap_ovf;
  int         lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One subtractor column: exact via arithmetic, approximate via truth tables
  function automatic logic [1:0] cell_m(input logic x, input logic y, input logic b, input logic ap);
    int t;
    if (ap) return {DIFF_TT[{x, y, b}], BOUT_TT[{x, y, b}]};
    t = int'(x) - int'(y) - int'(b);
    return {t[0], (t < 0)};
  endfunction

  // Triangular restoring array: returns {q, r}
  function automatic logic [15:0] model_div(input logic [15:0] nn, input logic [7:0] dd, input logic ae);
    logic [7:0] rem, qq, x, df;
    logic       g, b, qb;
    logic [1:0] cr;
    rem = nn[15:8];
    qq  = '0;
    for (int i = 7; i >= 0; i--) begin
      g = rem[7];
      x = {rem[6:0], nn[i]};
      b = 1'b0;
      for (int c = 0; c < 8; c++) begin
        cr    = cell_m(x[c], dd[c], b, ae && (c < APPROX_LSBS));
        df[c] = cr[1];
        b     = cr[0];
      end
      qb    = g | ~b;
      rem   = qb ? df : x;
      qq[i] = qb;
    end
    return {qq, rem};
  endfunction

  task automatic run_op(input logic [15:0] nn, input logic [7:0] dd, input logic ae, input int hold);
    int wcnt;
    wcnt = 0;
    @(negedge clk);
    while (!bus.in_ready && wcnt < 50) begin
      @(negedge clk);
      wcnt++;
    end
    if (!bus.in_ready) check("ready_timeout", 32'd0, 32'd1);
    bus.n         = nn;
    bus.d         = dd;
    bus.approx_en = ae;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) check("done_timeout", 32'd0, 32'd1);
    cap_q   = bus.q;
    cap_r   = bus.r;
    cap_dbz = bus.dbz;
    cap_ovf = bus.ovf;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_q",         32'(bus.q),         32'(cap_q));
      check("hold_r",         32'(bus.r),         32'(cap_r));
      check("hold_flags",     32'({bus.dbz, bus.ovf}), 32'({cap_dbz, cap_ovf}));
      check("hold_in_ready",  32'(bus.in_ready),  32'd0);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic check_vs_model(input string tag, input logic [15:0] nn, input logic [7:0] dd, input logic ae);
    logic [15:0] m;
    m = model_div(nn, dd, ae);
    check({tag, "_q"},   32'(cap_q),   32'(m[15:8]));
    check({tag, "_r"},   32'(cap_r),   32'(m[7:0]));
    check({tag, "_dbz"}, 32'(cap_dbz), 32'(dd == 8'd0));
    check({tag, "_ovf"}, 32'(cap_ovf), 32'(nn[15:8] >= dd));
  endtask

  initial begin
    logic [15:0] nn;
    logic [7:0]  dd;
    logic        ae;
    int          seen_valid;
    real         err_sum [2];
    int          err_cnt [2];
    int          tq;

    bus.in_valid  = 1'b0;
    bus.n         = '0;
    bus.d         = '0;
    bus.approx_en = 1'b0;
    bus.out_ready = 1'b0;
    err_sum[0] = 0.0; err_sum[1] = 0.0;
    err_cnt[0] = 0;   err_cnt[1] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_qr",        32'({bus.q, bus.r}), 32'd0);
    check("rst_flags",     32'({bus.dbz, bus.ovf}), 32'd0);
    rst = 1'b0;

    // 1: exact division with latency
    run_op(16'd1000, 8'd7, 1'b0, 0);
    check("t1_latency", 32'(lat), 32'(W + 1));
    check("t1_q",   32'(cap_q),   32'd142);
    check("t1_r",   32'(cap_r),   32'd6);
    check("t1_dbz", 32'(cap_dbz), 32'd0);
    check("t1_ovf", 32'(cap_ovf), 32'd0);

    // 2: divide by zero
    run_op(16'h1234, 8'd0, 1'b0, 0);
    check("t2_q",   32'(cap_q),   32'hFF);
    check("t2_r",   32'(cap_r),   32'h34);
    check("t2_dbz", 32'(cap_dbz), 32'd1);
    check("t2_ovf", 32'(cap_ovf), 32'd1);

    // 3: overflow, both modes
    run_op(16'h0A00, 8'd5, 1'b0, 0);
    check_vs_model("t3e", 16'h0A00, 8'd5, 1'b0);
    run_op(16'h0A00, 8'd5, 1'b1, 0);
    check_vs_model("t3a", 16'h0A00, 8'd5, 1'b1);

    // 5: backpressure
    run_op(16'd50000, 8'd211, 1'b1, 5);
    check_vs_model("t5", 16'd50000, 8'd211, 1'b1);
    @(negedge clk);
    check("t5_idle_in_ready", 32'(bus.in_ready), 32'd1);

    // 6: reset in the middle of a division
    @(negedge clk);
    bus.n = 16'd40000; bus.d = 8'd200; bus.approx_en = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_busy_before", 32'({bus.busy, bus.in_ready}), 32'b10);
    rst = 1'b1;
    #1;
    check("t6_in_ready", 32'(bus.in_ready),  32'd1);
    check("t6_idle",     32'({bus.out_valid, bus.busy}), 32'd0);
    check("t6_qr",       32'({bus.q, bus.r}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid++;
    end
    check("t6_no_out_valid", 32'(seen_valid), 32'd0);
    run_op(16'd40000, 8'd200, 1'b0, 0);
    check("t6_next_q", 32'(cap_q), 32'd200);
    check("t6_next_r", 32'(cap_r), 32'd0);

    // 4: randomized against the array model, plus true division in exact mode
    for (int k = 0; k < 2000; k++) begin
      dd = 8'($urandom_range(0, 255));
      if (($urandom_range(0, 15) == 0)) dd = 8'd0;
      nn = 16'($urandom);
      if (($urandom & 1) && dd != 8'd0) nn[15:8] = 8'($urandom_range(0, int'(dd) - 1));
      ae = 1'($urandom);
      run_op(nn, dd, ae, 0);
      check_vs_model("t4", nn, dd, ae);
      if (dd != 8'd0 && nn[15:8] < dd) begin
        tq = int'(nn) / int'(dd);
        err_sum[ae] += (int'(cap_q) > tq) ? real'(int'(cap_q) - tq) : real'(tq - int'(cap_q));
        err_cnt[ae]++;
        if (!ae) begin
          check("t4_true_q", 32'(cap_q), 32'(tq));
          check("t4_true_r", 32'(cap_r), 32'(int'(nn) % int'(dd)));
        end
      end
    end
    for (int m = 0; m < 2; m++)
      $display("[TB] approx_en=%0d quotient MAE %f over %0d samples", m,
               (err_cnt[m] > 0) ? err_sum[m] / real'(err_cnt[m]) : 0.0, err_cnt[m]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
